// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared constants and FSM encodings for the serial path
package bit_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  localparam int SER_MIN_WIDTH = 2;
  localparam int SER_MAX_WIDTH = 16;
  localparam int DET_RUN_LEN   = 4;

endpackage

// File: rtl/arst_reg.sv
// rtl/arst_reg.sv - enabled register with asynchronous active-low reset
module arst_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel word to registered serial bit stream
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_raw_q;
  ser_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             shreg_en;
  logic             bit_q, bit_d;
  logic             last_bit;
  logic             accept;

  assign state_q    = ser_state_e'(state_raw_q);
  assign last_bit   = (state_q == ST_SHIFT) && (count_q == LAST);
  // Gated by reset so no word can be offered as accepted while the block is held.
  assign din_ready  = reset & ((state_q == ST_IDLE) | last_bit);
  assign accept     = din_valid & din_ready;
  assign bit_valid  = (state_q == ST_SHIFT);
  assign frame_done = last_bit;
  assign bit_out    = bit_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shreg_d  = shreg_q;
    shreg_en = 1'b0;
    bit_d    = bit_q;
    case (state_q)
      ST_IDLE: begin
        bit_d = IDLE_BIT;
        if (accept) begin
          state_d  = ST_SHIFT;
          count_d  = '0;
          shreg_d  = din;
          shreg_en = 1'b1;
          bit_d    = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          count_d  = '0;
          shreg_d  = din;
          shreg_en = 1'b1;
          bit_d    = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];
        end else if (last_bit) begin
          state_d = ST_IDLE;
          count_d = '0;
          bit_d   = IDLE_BIT;
        end else begin
          // The bit on the output is always the one at the shift-out end of shreg_q.
          count_d  = count_q + 1'b1;
          shreg_en = 1'b1;
          shreg_d  = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
          bit_d    = (LSB_FIRST != 0) ? shreg_q[1] : shreg_q[WIDTH-2];
        end
      end
    endcase
  end

  arst_reg #(.WIDTH(1), .RESET_VAL(ST_IDLE)) u_state_reg (
    .clk(clk), .rst_n(reset), .en(1'b1), .d(state_d), .q(state_raw_q)
  );

  arst_reg #(.WIDTH(CW), .RESET_VAL('0)) u_count_reg (
    .clk(clk), .rst_n(reset), .en(1'b1), .d(count_d), .q(count_q)
  );

  arst_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_shreg_reg (
    .clk(clk), .rst_n(reset), .en(shreg_en), .d(shreg_d), .q(shreg_q)
  );

  arst_reg #(.WIDTH(1), .RESET_VAL(IDLE_BIT)) u_bit_reg (
    .clk(clk), .rst_n(reset), .en(1'b1), .d(bit_d), .q(bit_q)
  );

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       dv8, rdy8, bo8, bv8, fd8;
  logic [7:0] din8;
  logic       dvm, rdym, bom, bvm, fdm;
  logic [7:0] dinm;
  logic       dv2, rdy2, bo2, bv2, fd2;
  logic [1:0] din2;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din_valid(dv8), .din(din8), .din_ready(rdy8),
    .bit_out(bo8), .bit_valid(bv8), .frame_done(fd8)
  );

  bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .din_valid(dvm), .din(dinm), .din_ready(rdym),
    .bit_out(bom), .bit_valid(bvm), .frame_done(fdm)
  );

  bit_serializer #(.WIDTH(2), .LSB_FIRST(1), .IDLE_BIT(1'b0)) u_w2 (
    .clk(clk), .reset(reset), .din_valid(dv2), .din(din2), .din_ready(rdy2),
    .bit_out(bo2), .bit_valid(bv2), .frame_done(fd2)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic [3:0] exp; // {bit_out, bit_valid, frame_done, din_ready}
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [7:0] d, input logic bo, input logic bv,
                     input logic fd, input logic rdy);
    vec_t v;
    v.dv = dv; v.d = d; v.exp = {bo, bv, fd, rdy};
    tbl.push_back(v);
  endtask

  bit         mq[$];
  logic       mrdy;
  logic [3:0] mexp;
  logic [7:0] pat;

  initial begin
    reset = 1'b0;
    dv8 = 0; din8 = '0; dvm = 0; dinm = '0; dv2 = 0; din2 = '0;
    repeat (3) tick();
    chk("reset_lsb", {bo8, bv8, fd8, rdy8}, 4'b0000);
    chk("reset_msb", {bom, bvm, fdm, rdym}, 4'b0000);
    chk("reset_w2", {bo2, bv2, fd2, rdy2}, 4'b0000);
    reset = 1'b1;
    #1;
    chk("post_reset_ready", rdy8, 1'b1);

    // 8'h0F single pulse, din_valid toggling during the non-last bits
    add(1, 8'h0F, 1, 1, 0, 0);
    for (int i = 1; i < 8; i++)
      add(logic'(i % 2), 8'hFF, (i < 4), 1, (i == 7), (i == 7));
    add(0, 8'h00, 0, 0, 0, 1);
    // din_valid held high, 8'hFF then 8'h00 back to back
    for (int i = 0; i < 8; i++) add(1, 8'hFF, 1, 1, (i == 7), (i == 7));
    for (int i = 0; i < 8; i++) add(1, 8'h00, 0, 1, (i == 7), (i == 7));
    add(0, 8'h00, 0, 0, 0, 1);

    foreach (tbl[k]) begin
      dv8 = tbl[k].dv; din8 = tbl[k].d;
      tick();
      chk($sformatf("vec[%0d]", k), {bo8, bv8, fd8, rdy8}, tbl[k].exp);
    end
    dv8 = 0;

    // MSB-first 8'hA5
    pat = 8'hA5;
    dvm = 1; dinm = pat;
    tick();
    dvm = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("msb_bit%0d", i), {bom, bvm, fdm}, {pat[7-i], 1'b1, (i == 7)});
      tick();
    end
    chk("msb_idle", {bom, bvm, rdym}, 3'b001);

    // WIDTH=2 back to back 01 then 10
    dv2 = 1; din2 = 2'b01;
    tick(); chk("w2_c1", {bo2, bv2, fd2}, 3'b110);
    din2 = 2'b10;
    tick(); chk("w2_c2", {bo2, bv2, fd2, rdy2}, 4'b0111);
    tick(); chk("w2_c3", {bo2, bv2, fd2}, 3'b010);
    dv2 = 0;
    tick(); chk("w2_c4", {bo2, bv2, fd2}, 3'b111);
    tick(); chk("w2_idle", {bo2, bv2}, 2'b00);

    // Asynchronous reset at bit 3 of 8'h3C
    dv8 = 1; din8 = 8'h3C;
    tick();
    dv8 = 0;
    repeat (3) tick();
    chk("arst_pre_bit3", {bo8, bv8}, 2'b11);
    #2 reset = 1'b0;
    #1 chk("arst_clear", {bo8, bv8, fd8, rdy8}, 4'b0000);
    tick();
    chk("arst_held", {bo8, bv8}, 2'b00);
    reset = 1'b1;
    #1 chk("arst_release", {bv8, rdy8}, 2'b01);
    dv8 = 1; din8 = 8'h81;
    tick(); chk("arst_first_accept", {bo8, bv8, fd8}, 3'b110);
    dv8 = 0;
    repeat (8) tick();
    chk("arst_drain_idle", {bv8, rdy8}, 2'b01);

    // Randomised traffic against a queue-of-bits reference model
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      dv8  = ($urandom_range(0, 2) != 0);
      din8 = 8'($urandom);
      mrdy = (mq.size() <= 1);
      tick();
      if (mq.size() > 0) void'(mq.pop_front());
      if (dv8 && mrdy) for (int i = 0; i < 8; i++) mq.push_back(din8[i]);
      mexp = {(mq.size() > 0) ? logic'(mq[0]) : 1'b0, (mq.size() > 0), (mq.size() == 1),
              (mq.size() <= 1)};
      chk($sformatf("rand[%0d]", c), {bo8, bv8, fd8, rdy8}, mexp);
    end
    dv8 = 0;
    repeat (10) tick();
    chk("rand_end_idle", {bv8, rdy8}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
